// File: rtl/read_pack_queue.sv
// Narrow-to-wide packer: gathers up to OUT_WIDTH/IN_WIDTH narrow words, LSB-first, into one wide word.
// An accumulator plus an output register let the input run at one word per cycle while the consumer keeps up.
module read_pack_queue #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 512
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [IN_WIDTH-1:0]                       din,
   input  logic                                      vld_in,
   input  logic                                      last_in,
   output logic                                      rdy_upward,
   output logic [OUT_WIDTH-1:0]                      dout,
   output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]       dout_words,
   output logic                                      dout_last,
   output logic                                      vld_out,
   input  logic                                      rdy_downward
);

   localparam int MAX = OUT_WIDTH / IN_WIDTH;
   localparam int CW  = $clog2(MAX);
   localparam int WW  = CW + 1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);
   localparam logic [WW-1:0] WRD_ONE  = WW'(1);

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   // Handshake: a word moves upstream when vld_in & rdy_upward at a rising clk edge;
   // a wide word moves downstream when vld_out & rdy_downward at a rising clk edge.
   logic [0:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [OUT_WIDTH-1:0] dout_q, dout_d;
   logic [WW-1:0]        words_q, words_d;
   logic                 last_q, last_d;
   logic                 vld_q, vld_d;
   logic [WW-1:0]        pend_words_q, pend_words_d;
   logic                 pend_last_q, pend_last_d;

   logic                 in_accept;
   logic                 closes;
   logic                 out_free;
   logic [WW-1:0]        n_words;
   logic [OUT_WIDTH-1:0] acc_wr;

   assign rdy_upward = (state_q == ST_FILL) && !reset;
   assign in_accept  = vld_in && rdy_upward;
   assign closes     = in_accept && ((cnt_q == CNT_LAST) || last_in);
   assign out_free   = !vld_q || rdy_downward;
   assign n_words    = {1'b0, cnt_q} + WRD_ONE;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      dout_d       = dout_q;
      words_d      = words_q;
      last_d       = last_q;
      vld_d        = vld_q;
      pend_words_d = pend_words_q;
      pend_last_d  = pend_last_q;

      // Upper slots of acc are always zero, so writing the current slot leaves them as padding.
      acc_wr = acc_q;
      acc_wr[cnt_q*IN_WIDTH +: IN_WIDTH] = din;

      if (vld_q && rdy_downward) begin
         vld_d = 1'b0;
      end

      case (state_q)
         ST_FILL: begin
            if (in_accept) begin
               if (closes) begin
                  if (out_free) begin
                     dout_d  = acc_wr;
                     words_d = n_words;
                     last_d  = last_in;
                     vld_d   = 1'b1;
                     acc_d   = '0;
                     cnt_d   = '0;
                  end else begin
                     acc_d        = acc_wr;
                     pend_words_d = n_words;
                     pend_last_d  = last_in;
                     state_d      = ST_STALL;
                  end
               end else begin
                  acc_d = acc_wr;
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_STALL: begin
            // vld_q is always set here, so rdy_downward alone means the old word left.
            if (rdy_downward) begin
               dout_d  = acc_q;
               words_d = pend_words_q;
               last_d  = pend_last_q;
               vld_d   = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FILL;
         cnt_q        <= '0;
         acc_q        <= '0;
         dout_q       <= '0;
         words_q      <= '0;
         last_q       <= 1'b0;
         vld_q        <= 1'b0;
         pend_words_q <= '0;
         pend_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         dout_q       <= dout_d;
         words_q      <= words_d;
         last_q       <= last_d;
         vld_q        <= vld_d;
         pend_words_q <= pend_words_d;
         pend_last_q  <= pend_last_d;
      end
   end

   assign dout       = dout_q;
   assign dout_words = words_q;
   assign dout_last  = last_q;
   assign vld_out    = vld_q;

endmodule

// File: tb/tb_read_pack_queue.sv
// Bench for read_pack_queue: directed steps then randomized traffic, checked against a
// word-list packet model and an expected-packet queue.
module tb_read_pack_queue;

   localparam int IW  = 32;
   localparam int OW  = 512;
   localparam int MAX = OW / IW;
   localparam int WW  = $clog2(MAX) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [IW-1:0] din = '0;
   logic          vld_in = 1'b0;
   logic          last_in = 1'b0;
   logic          rdy_upward;
   logic [OW-1:0] dout;
   logic [WW-1:0] dout_words;
   logic          dout_last;
   logic          vld_out;
   logic          rdy_downward = 1'b0;

   int checks = 0;
   int errors = 0;
   bit rand_mode = 1'b0;

   logic [IW-1:0] part_q[$];
   logic [OW-1:0] exp_q[$];
   int            exp_words_q[$];
   bit            exp_last_q[$];
   logic [OW-1:0] mon_data;
   logic [OW-1:0] mon_exp;

   read_pack_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .vld_in       (vld_in),
      .last_in      (last_in),
      .rdy_upward   (rdy_upward),
      .dout         (dout),
      .dout_words   (dout_words),
      .dout_last    (dout_last),
      .vld_out      (vld_out),
      .rdy_downward (rdy_downward)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) rdy_downward = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      vld_in  = 1'b0;
      last_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_word(input logic [IW-1:0] d, input bit l);
      bit took;
      took    = 1'b0;
      vld_in  = 1'b1;
      din     = d;
      last_in = l;
      for (int c = 0; c < 1000 && !took; c++) begin
         @(negedge clk);
         took = rdy_upward;
         tick();
      end
      if (!took) begin
         checks++;
         errors++;
         $error("FAIL accept_timeout: word %0h not taken, expected acceptance within 1000 cycles", d);
      end
   endtask

   // Packet model: accepted words collect in a list; a list closes at MAX words or on last_in.
   always @(negedge clk) begin
      if (!reset) begin
         if (vld_out && rdy_downward) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_output: observed dout %0h, expected no output", dout);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("sb_dout", dout, mon_exp);
               chk("sb_words", OW'(dout_words), OW'(exp_words_q.pop_front()));
               chk("sb_last", OW'(dout_last), OW'(exp_last_q.pop_front()));
            end
         end
         if (vld_in && rdy_upward) begin
            part_q.push_back(din);
            if (part_q.size() == MAX || last_in) begin
               mon_data = '0;
               foreach (part_q[k]) mon_data = mon_data | (OW'(part_q[k]) << (IW * k));
               exp_q.push_back(mon_data);
               exp_words_q.push_back(part_q.size());
               exp_last_q.push_back(last_in);
               part_q.delete();
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld_out", OW'(vld_out), OW'(0));
      chk("rst_dout", dout, OW'(0));
      chk("rst_words", OW'(dout_words), OW'(0));
      chk("rst_last", OW'(dout_last), OW'(0));
      chk("rst_rdy_up", OW'(rdy_upward), OW'(0));
      reset = 1'b0;
      rdy_downward = 1'b1;
      tick();
      chk("post_rst_rdy_up", OW'(rdy_upward), OW'(1));

      // 1: one full packet with the consumer ready
      for (int i = 0; i < 15; i++) send_word(IW'(i), 1'b0);
      chk("t1_vld_before", OW'(vld_out), OW'(0));
      send_word(IW'(15), 1'b0);
      chk("t1_vld_latency", OW'(vld_out), OW'(1));
      chk("t1_words", OW'(dout_words), OW'(16));
      chk("t1_last", OW'(dout_last), OW'(0));
      chk("t1_word1", OW'(dout[63:32]), OW'(1));
      chk("t1_rdy_up", OW'(rdy_upward), OW'(1));
      idle(1);
      chk("t1_vld_pulse", OW'(vld_out), OW'(0));

      // 2: consumer stalled, second packet waits in the accumulator
      rdy_downward = 1'b0;
      for (int i = 0; i < 32; i++) send_word(IW'(i), 1'b0);
      idle(0);
      chk("t2_rdy_up_low", OW'(rdy_upward), OW'(0));
      chk("t2_vld", OW'(vld_out), OW'(1));
      chk("t2_p0_w15", OW'(dout[511:480]), OW'(15));
      idle(2);
      chk("t2_hold_w0", OW'(dout[31:0]), OW'(0));
      rdy_downward = 1'b1;
      tick();
      chk("t2_p1_w0", OW'(dout[31:0]), OW'(16));
      chk("t2_p1_vld", OW'(vld_out), OW'(1));
      chk("t2_rdy_up_back", OW'(rdy_upward), OW'(1));
      tick();
      chk("t2_drained", OW'(vld_out), OW'(0));

      // 3: short packets closed by last_in
      for (int i = 0; i < 5; i++) send_word(IW'(32'hA0 + i), i == 4);
      chk("t3_words", OW'(dout_words), OW'(5));
      chk("t3_last", OW'(dout_last), OW'(1));
      chk("t3_w4", OW'(dout[159:128]), OW'(32'hA4));
      chk("t3_pad", OW'(dout[511:160]), OW'(0));
      send_word(IW'(32'hB0), 1'b1);
      chk("t3_single_words", OW'(dout_words), OW'(1));
      chk("t3_single_pad", OW'(dout[511:32]), OW'(0));
      chk("t3_single_w0", OW'(dout[31:0]), OW'(32'hB0));

      // 4: last_in on the final slot, then a normal packet
      for (int i = 0; i < 16; i++) send_word(IW'(32'hC0 + i), i == 15);
      chk("t4_words", OW'(dout_words), OW'(16));
      chk("t4_last", OW'(dout_last), OW'(1));
      for (int i = 0; i < 16; i++) send_word(IW'(32'hD0 + i), 1'b0);
      chk("t4_next_last", OW'(dout_last), OW'(0));
      chk("t4_next_w0", OW'(dout[31:0]), OW'(32'hD0));
      idle(1);

      // 5: reset mid-packet with a pending output word
      rdy_downward = 1'b0;
      for (int i = 0; i < 16; i++) send_word(IW'(32'hE0 + i), 1'b0);
      for (int i = 0; i < 7; i++) send_word(IW'(32'hF0 + i), 1'b0);
      idle(0);
      chk("t5_pending", OW'(vld_out), OW'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_vld", OW'(vld_out), OW'(0));
      chk("t5_rst_dout", dout, OW'(0));
      chk("t5_rst_rdy_up", OW'(rdy_upward), OW'(0));
      part_q.delete();
      exp_q.delete();
      exp_words_q.delete();
      exp_last_q.delete();
      reset = 1'b0;
      rdy_downward = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) send_word(IW'(32'h100 + i), 1'b0);
      chk("t5_clean_w0", OW'(dout[31:0]), OW'(32'h100));
      chk("t5_clean_w15", OW'(dout[511:480]), OW'(32'h10F));
      chk("t5_clean_words", OW'(dout_words), OW'(16));
      idle(1);

      // 6: random traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 480; i++) begin
         idle($urandom_range(0, 2));
         send_word($urandom, $urandom_range(0, 7) == 0);
      end
      rand_mode = 1'b0;
      rdy_downward = 1'b1;
      send_word(IW'(32'hDEAD), 1'b1);
      idle(0);
      for (int c = 0; c < 100 && (exp_q.size() != 0 || vld_out); c++) tick();
      chk("t6_exp_empty", OW'(exp_q.size()), OW'(0));
      chk("t6_part_empty", OW'(part_q.size()), OW'(0));
      chk("t6_vld_idle", OW'(vld_out), OW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
